// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, one-word-per-line instruction cache that sits
// between the fetch stage and the memory controller's instruction port.
//
// Hits are answered combinationally in the cycle the request is presented.
// A miss raises a registered single-word fetch request (icache_needed /
// icache_addr) that stays stable until the memory controller pulses
// inst_data_enable; the returned word is written into the line and, if fetch
// is still asking for that word, forwarded in the same cycle. While a fill is
// outstanding, hits to other resident lines are still served.
//
// Handshake: icache_needed is a level request held high with a constant
// icache_addr from the cycle after the miss until the cycle after the single
// inst_data_enable pulse; the memory controller owns the timing of that pulse
// and the cache never withdraws a request early (only reset drops it).
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-low reset
//   if_req/if_addr   fetch request and address (bits [1:0] ignored)
//   if_valid/if_inst instruction returned to fetch (if_inst is 0 when !if_valid)
//   icache_flush     invalidate every line at the next edge
//   icache_needed    registered miss request to the memory controller
//   icache_addr      registered word-aligned miss address
//   inst_i           word from the memory controller
//   inst_data_enable one-cycle pulse qualifying inst_i
//   hit_cnt/miss_cnt wrapping performance counters
//   dbg_state        current FSM state (0 = IDLE, 1 = MISS)
module inst_cache #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    input  logic              icache_flush,
    output logic              icache_needed,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic [INST_W-1:0] inst_i,
    input  logic              inst_data_enable,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic              dbg_state
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                needed_q, needed_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    // Set when a flush lands while a fill is outstanding: the word that
    // eventually arrives belongs to the pre-flush program image.
    logic                discard_q, discard_d;
    logic [31:0]         hit_cnt_q, miss_cnt_q;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [INST_W-1:0]   data_q [LINES];

    logic [INDEX_W-1:0]  if_index;
    logic [TAG_W-1:0]    if_tag;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                bypass;
    logic                miss_start;
    logic                fill_write;

    // Byte offset within the word never selects anything.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    assign if_index   = if_addr[INDEX_W+1:2];
    assign if_tag     = if_addr[ADDR_W-1:INDEX_W+2];
    assign fill_index = miss_addr_q[INDEX_W+1:2];
    assign fill_tag   = miss_addr_q[ADDR_W-1:INDEX_W+2];

    assign hit = if_req && valid_q[if_index] && (tag_q[if_index] == if_tag)
                 && !icache_flush;

    // Next-state and fill control.
    always_comb begin
        state_d     = state_q;
        needed_d    = needed_q;
        miss_addr_d = miss_addr_q;
        discard_d   = discard_q;
        miss_start  = 1'b0;
        fill_write  = 1'b0;
        bypass      = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req && !hit && !icache_flush) begin
                    state_d     = MISS;
                    needed_d    = 1'b1;
                    miss_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
                    miss_start  = 1'b1;
                end
            end
            MISS: begin
                if (icache_flush) begin
                    discard_d = 1'b1;
                end
                if (inst_data_enable) begin
                    state_d   = IDLE;
                    needed_d  = 1'b0;
                    discard_d = 1'b0;
                    // A flush in the fill cycle itself also kills the fill.
                    if (!discard_q && !icache_flush) begin
                        fill_write = 1'b1;
                        if (if_req && (if_addr[ADDR_W-1:2] == miss_addr_q[ADDR_W-1:2])) begin
                            bypass = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch-side outputs; forced quiet while reset is asserted.
    always_comb begin
        if_valid = 1'b0;
        if_inst  = '0;
        if (rst) begin
            if (bypass) begin
                if_valid = 1'b1;
                if_inst  = inst_i;
            end else if (hit) begin
                if_valid = 1'b1;
                if_inst  = data_q[if_index];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            needed_q    <= 1'b0;
            miss_addr_q <= '0;
            discard_q   <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            needed_q    <= needed_d;
            miss_addr_q <= miss_addr_d;
            discard_q   <= discard_d;
            if (if_valid) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (icache_flush) begin
                valid_q <= '0;
            end else if (fill_write) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (fill_write) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= inst_i;
        end
    end

    assign icache_needed = needed_q;
    assign icache_addr   = miss_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign dbg_state     = (state_q == MISS);

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: a table of fetch vectors, a randomised fetch phase
// tracked by a small line model, and hand sequences for hit-under-miss,
// flush during a fill, reset during a fill and stray data pulses.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        icache_flush;
    logic        icache_needed;
    logic [31:0] icache_addr;
    logic [31:0] inst_i;
    logic        inst_data_enable;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        dbg_state;

    inst_cache #(.ADDR_W(32), .INST_W(32), .INDEX_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_valid         (if_valid),
        .if_inst          (if_inst),
        .icache_flush     (icache_flush),
        .icache_needed    (icache_needed),
        .icache_addr      (icache_addr),
        .inst_i           (inst_i),
        .inst_data_enable (inst_data_enable),
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          m_hits   = 0;
    int          m_misses = 0;
    bit          m_v [64];
    logic [31:0] m_a [64];

    typedef struct packed {
        logic [31:0] addr;
        logic        exp_hit;
        logic [3:0]  lat;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] pool [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) + 32'h0000_0013;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_v[a[7:2]] && (m_a[a[7:2]] == (a & 32'hFFFF_FFFC));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: nothing expected, got %h", name, if_inst);
        end else begin
            e = exp_q.pop_front();
            chk(name, if_inst, e);
        end
    endtask

    task automatic chk_counters(input string name);
        chk({name, "_hit_cnt"}, hit_cnt, m_hits);
        chk({name, "_miss_cnt"}, miss_cnt, m_misses);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at a falling edge with if_req low.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input int lat, input string name);
        if_req  = 1'b1;
        if_addr = a;
        #1;
        chk({name, "_valid"}, if_valid, exp_hit);
        if (exp_hit) begin
            exp_q.push_back(mem_word(a));
            pop_check({name, "_hit_inst"});
            m_hits++;
            @(negedge clk);
            if_req = 1'b0;
        end else begin
            m_misses++;
            @(negedge clk);
            chk({name, "_needed"}, icache_needed, 1);
            chk({name, "_maddr"}, icache_addr, a & 32'hFFFF_FFFC);
            chk({name, "_state"}, dbg_state, 1);
            for (int i = 0; i < lat; i++) begin
                chk({name, "_wait_valid"}, if_valid, 0);
                @(negedge clk);
            end
            inst_i           = mem_word(a);
            inst_data_enable = 1'b1;
            exp_q.push_back(mem_word(a));
            #1;
            chk({name, "_bypass_valid"}, if_valid, 1);
            pop_check({name, "_bypass_inst"});
            m_hits++;
            @(negedge clk);
            inst_data_enable = 1'b0;
            if_req           = 1'b0;
            chk({name, "_needed_drop"}, icache_needed, 0);
            m_v[a[7:2]] = 1'b1;
            m_a[a[7:2]] = a & 32'hFFFF_FFFC;
        end
        chk_counters(name);
    endtask

    // ---------------- test ----------------
    initial begin
        rst              = 1'b0;
        if_req           = 1'b0;
        if_addr          = '0;
        icache_flush     = 1'b0;
        inst_i           = '0;
        inst_data_enable = 1'b0;
        model_clear();

        vecs[0]  = '{32'h0000_0000, 1'b0, 4'd2};
        vecs[1]  = '{32'h0000_0000, 1'b1, 4'd0};
        vecs[2]  = '{32'h0000_0004, 1'b0, 4'd1};
        vecs[3]  = '{32'h0000_0104, 1'b0, 4'd3};
        vecs[4]  = '{32'h0000_0104, 1'b1, 4'd0};
        vecs[5]  = '{32'h0000_0004, 1'b0, 4'd0};
        vecs[6]  = '{32'h0000_0004, 1'b1, 4'd0};
        vecs[7]  = '{32'h0000_0000, 1'b1, 4'd0};
        vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 4'd1};
        vecs[9]  = '{32'hFFFF_FFFD, 1'b1, 4'd0};
        vecs[10] = '{32'h0000_00FC, 1'b0, 4'd2};
        vecs[11] = '{32'hFFFF_FFFC, 1'b0, 4'd1};

        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0004;
        pool[2] = 32'h0000_0104; pool[3] = 32'h0000_0204;
        pool[4] = 32'h0000_0040; pool[5] = 32'h0000_1040;
        pool[6] = 32'h0000_00FC; pool[7] = 32'h0000_0008;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_needed", icache_needed, 0);
        chk("rst_maddr", icache_addr, 0);
        chk("rst_state", dbg_state, 0);
        chk_counters("rst");
        rst = 1'b1;
        @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            fetch(vecs[i].addr, vecs[i].exp_hit, int'(vecs[i].lat), $sformatf("vec%0d", i));
        end

        // Random fetches against the line model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 7)];
            fetch(a, model_hit(a), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Hit-under-miss with the request moving away before the fill.
        if (!model_hit(32'h0)) fetch(32'h0, 1'b0, 1, "a_prime");
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        #1;
        chk("a_miss_valid", if_valid, 0);
        m_misses++;
        @(negedge clk);
        chk("a_needed", icache_needed, 1);
        chk("a_maddr", icache_addr, 32'h10);
        if_addr = 32'h0000_0000;
        #1;
        chk("a_hum_valid", if_valid, 1);
        exp_q.push_back(32'h0000_0013);
        pop_check("a_hum_inst");
        m_hits++;
        @(negedge clk);
        chk("a_maddr_held", icache_addr, 32'h10);
        chk("a_needed_held", icache_needed, 1);
        if_addr          = 32'h0000_0020;
        inst_i           = mem_word(32'h10);
        inst_data_enable = 1'b1;
        #1;
        chk("a_nobypass_valid", if_valid, 0);
        chk("a_nobypass_inst", if_inst, 0);
        @(negedge clk);
        inst_data_enable = 1'b0;
        if_req           = 1'b0;
        chk("a_needed_drop", icache_needed, 0);
        chk("a_maddr_after", icache_addr, 32'h10);
        m_v[4] = 1'b1;
        m_a[4] = 32'h10;
        chk_counters("a");
        fetch(32'h0000_0010, 1'b1, 0, "a_refetch");

        // Flush while a fill is outstanding.
        if_req  = 1'b1;
        if_addr = 32'h0000_0020;
        #1;
        chk("b_miss_valid", if_valid, 0);
        m_misses++;
        @(negedge clk);
        chk("b_needed", icache_needed, 1);
        if_addr      = 32'h0000_0000;
        icache_flush = 1'b1;
        #1;
        chk("b_flush_valid", if_valid, 0);
        chk("b_flush_inst", if_inst, 0);
        @(negedge clk);
        icache_flush = 1'b0;
        model_clear();
        chk("b_needed_kept", icache_needed, 1);
        if_addr          = 32'h0000_0020;
        inst_i           = mem_word(32'h20);
        inst_data_enable = 1'b1;
        #1;
        chk("b_discard_valid", if_valid, 0);
        @(negedge clk);
        inst_data_enable = 1'b0;
        if_req           = 1'b0;
        chk("b_needed_drop", icache_needed, 0);
        chk("b_state", dbg_state, 0);
        chk_counters("b");
        fetch(32'h0000_0000, 1'b0, 1, "b_post0");
        fetch(32'h0000_0020, 1'b0, 2, "b_post20");

        // Reset in the middle of a fill.
        if_req  = 1'b1;
        if_addr = 32'h0000_0030;
        @(negedge clk);
        chk("c_needed", icache_needed, 1);
        if_addr = 32'h0000_0000;
        #1;
        chk("c_hum_valid", if_valid, 1);
        exp_q.push_back(32'h0000_0013);
        pop_check("c_hum_inst");
        rst = 1'b0;
        #1;
        m_hits   = 0;
        m_misses = 0;
        model_clear();
        chk("c_needed_drop", icache_needed, 0);
        chk("c_maddr", icache_addr, 0);
        chk("c_valid", if_valid, 0);
        chk("c_inst", if_inst, 0);
        chk("c_state", dbg_state, 0);
        chk_counters("c");
        @(negedge clk);
        if_req = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        fetch(32'h0000_0000, 1'b0, 1, "c_post0");

        // Data pulse while idle is ignored.
        inst_i           = 32'hDEAD_BEEF;
        inst_data_enable = 1'b1;
        @(negedge clk);
        inst_data_enable = 1'b0;
        chk("d_needed", icache_needed, 0);
        chk("d_state", dbg_state, 0);
        chk_counters("d");
        fetch(32'h0000_2008, 1'b0, 1, "d_fetch");
        fetch(32'h0000_2008, 1'b1, 0, "d_refetch");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_leftover: %0d entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
